systolic_feeder: RTL and testbench

Tile sequencer on the input side of the TPU systolic array. It accepts one weight tile and one data tile over valid/ready streams, buffers both, then drives the array's `control`, `wt_arr` and `data_arr` pins itself. Weights are loaded in DEPTH contiguous cycles with `control=1`, followed by the diagonally skewed data stream. This replaces hand-sequenced stimulus, so the array can be fed from a DMA or pixel source that stalls freely.

---
 rtl/systolic_feeder.sv | 191 +++++++++++++++++++
 tb/tb_systolic_feeder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Input-side tile sequencer for the systolic array: buffers one weight tile and one
// data tile from valid/ready streams, then plays weights out followed by skewed data.
module systolic_feeder #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned BIT_WIDTH = 8,
    parameter int unsigned MAX_ROWS  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]   n_rows,
    input  logic                            wt_valid,
    output logic                            wt_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0]      wt_in,
    input  logic                            data_valid,
    output logic                            data_ready,
    input  logic [BIT_WIDTH*DEPTH-1:0]      data_in,
    output logic                            control,
    output logic [BIT_WIDTH*DEPTH-1:0]      wt_arr,
    output logic [BIT_WIDTH*DEPTH-1:0]      data_arr,
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned DW = BIT_WIDTH * DEPTH;
    localparam int unsigned NW = $clog2(MAX_ROWS + 1);
    localparam int unsigned CW = $clog2(MAX_ROWS + DEPTH + 1);
    localparam int unsigned KW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned RW = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL_W = 3'd1,
        FILL_D = 3'd2,
        SEND_W = 3'd3,
        SEND_D = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DW-1:0]   wbuf_q [DEPTH];
    logic [DW-1:0]   wbuf_d [DEPTH];
    logic [DW-1:0]   dbuf_q [MAX_ROWS];
    logic [DW-1:0]   dbuf_d [MAX_ROWS];

    logic            control_q, control_d;
    logic [DW-1:0]   wt_arr_q, wt_arr_d;
    logic [DW-1:0]   data_arr_q, data_arr_d;
    logic            wt_ready_q, wt_ready_d;
    logic            data_ready_q, data_ready_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            skew_en;
    logic [CW-1:0]   t_sel;
    logic [RW-1:0]   rix;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        wbuf_d     = wbuf_q;
        dbuf_d     = dbuf_q;
        control_d  = 1'b0;
        wt_arr_d   = '0;
        data_arr_d = '0;
        done_d     = 1'b0;
        skew_en    = 1'b0;
        t_sel      = '0;
        rix        = '0;

        case (state_q)
            IDLE: begin
                if (start && (n_rows != '0)) begin
                    n_d     = (n_rows > NW'(MAX_ROWS)) ? NW'(MAX_ROWS) : n_rows;
                    cnt_d   = '0;
                    state_d = FILL_W;
                end
            end
            FILL_W: begin
                if (wt_valid && wt_ready_q) begin
                    wbuf_d[KW'(cnt_q)] = wt_in;
                    if (cnt_q == CW'(DEPTH - 1)) begin
                        cnt_d   = '0;
                        state_d = FILL_D;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            FILL_D: begin
                if (data_valid && data_ready_q) begin
                    dbuf_d[RW'(cnt_q)] = data_in;
                    if (cnt_q == CW'(n_q) - CW'(1)) begin
                        cnt_d     = '0;
                        state_d   = SEND_W;
                        control_d = 1'b1;
                        wt_arr_d  = wbuf_q[0];
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            SEND_W: begin
                if (cnt_q == CW'(DEPTH - 1)) begin
                    cnt_d   = '0;
                    state_d = SEND_D;
                    skew_en = 1'b1;
                end else begin
                    cnt_d     = cnt_q + CW'(1);
                    control_d = 1'b1;
                    wt_arr_d  = wbuf_q[KW'(cnt_q + CW'(1))];
                end
            end
            SEND_D: begin
                if (cnt_q == CW'(n_q) + CW'(DEPTH) - CW'(2)) begin
                    cnt_d   = '0;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    skew_en = 1'b1;
                    t_sel   = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Output registers look one cycle ahead: lane j shows row (t - j) of the buffer.
        if (skew_en) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((t_sel >= CW'(j)) && ((t_sel - CW'(j)) < CW'(n_q))) begin
                    rix = RW'(t_sel - CW'(j));
                    data_arr_d[j*BIT_WIDTH +: BIT_WIDTH] = dbuf_q[rix][j*BIT_WIDTH +: BIT_WIDTH];
                end
            end
        end

        wt_ready_d   = (state_d == FILL_W);
        data_ready_d = (state_d == FILL_D);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            n_q          <= '0;
            control_q    <= 1'b0;
            wt_arr_q     <= '0;
            data_arr_q   <= '0;
            wt_ready_q   <= 1'b0;
            data_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            n_q          <= n_d;
            control_q    <= control_d;
            wt_arr_q     <= wt_arr_d;
            data_arr_q   <= data_arr_d;
            wt_ready_q   <= wt_ready_d;
            data_ready_q <= data_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Tile buffers carry no reset; their contents are only read after being written.
    always_ff @(posedge clk) begin
        wbuf_q <= wbuf_d;
        dbuf_q <= dbuf_d;
    end

    assign control    = control_q;
    assign wt_arr     = wt_arr_q;
    assign data_arr   = data_arr_q;
    assign wt_ready   = wt_ready_q;
    assign data_ready = data_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder: canonical, backpressured, N=1, clamped and
// interrupted tiles, each checked cycle by cycle against hand-derived sequences.
module tb_systolic_feeder;

    localparam int unsigned DEPTH     = 4;
    localparam int unsigned BIT_WIDTH = 8;
    localparam int unsigned MAX_ROWS  = 8;
    localparam int unsigned DW        = DEPTH * BIT_WIDTH;
    localparam int unsigned NW        = $clog2(MAX_ROWS + 1);

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] n_rows;
    logic          wt_valid;
    logic          wt_ready;
    logic [DW-1:0] wt_in;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] data_in;
    logic          control;
    logic [DW-1:0] wt_arr;
    logic [DW-1:0] data_arr;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wts   [4];
    logic [31:0] rows  [12];
    logic [31:0] exp_d [16];

    systolic_feeder #(
        .DEPTH     (DEPTH),
        .BIT_WIDTH (BIT_WIDTH),
        .MAX_ROWS  (MAX_ROWS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n_rows     (n_rows),
        .wt_valid   (wt_valid),
        .wt_ready   (wt_ready),
        .wt_in      (wt_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data_in    (data_in),
        .control    (control),
        .wt_arr     (wt_arr),
        .data_arr   (data_arr),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_control"},  32'(control),    32'h0);
        check({tag, "_wt_arr"},   32'(wt_arr),     32'h0);
        check({tag, "_data_arr"}, 32'(data_arr),   32'h0);
        check({tag, "_wt_rdy"},   32'(wt_ready),   32'h0);
        check({tag, "_d_rdy"},    32'(data_ready), 32'h0);
        check({tag, "_busy"},     32'(busy),       32'h0);
        check({tag, "_done"},     32'(done),       32'h0);
    endtask

    function automatic logic [31:0] model_skew(input int t, input int n);
        logic [31:0] v;
        logic [31:0] r;
        v = '0;
        for (int j = 0; j < int'(DEPTH); j++) begin
            if (t - j >= 0 && t - j < n) begin
                r = rows[t - j];
                v[j*8 +: 8] = r[j*8 +: 8];
            end
        end
        return v;
    endfunction

    task automatic load_canonical();
        wts[0] = 32'h00000001; wts[1] = 32'h00000100;
        wts[2] = 32'h00010000; wts[3] = 32'h01000000;
        rows[0] = 32'h00010101; rows[1] = 32'h02010202;
        rows[2] = 32'h04030100; rows[3] = 32'h05010200;
        exp_d[0] = 32'h00000001; exp_d[1] = 32'h00000102;
        exp_d[2] = 32'h00010200; exp_d[3] = 32'h00010100;
        exp_d[4] = 32'h02030200; exp_d[5] = 32'h04010000;
        exp_d[6] = 32'h05000000;
    endtask

    // mode 0: plain tile, 1: start pulsed in SEND_D cycle 2, 2: reset in SEND_D cycle 2
    task automatic run_tile(input int nreq, input int nacc, input bit stall,
                            input int mode, input int ncyc);
        int  iw;
        int  id;
        bit  ph;
        bit  tw;
        bit  td;
        iw = 0;
        id = 0;
        ph = 1'b0;

        start  = 1'b1;
        n_rows = NW'(nreq);
        step();
        start  = 1'b0;
        n_rows = '0;
        check("start_busy",  32'(busy),     32'h1);
        check("start_wtrdy", 32'(wt_ready), 32'h1);

        for (int c = 0; c < 200 && id < nacc; c++) begin
            wt_valid   = (iw < int'(DEPTH)) && !(stall && ph);
            wt_in      = wts[iw % 4];
            data_valid = (id < nreq) && !(stall && ph);
            data_in    = rows[id % 12];
            tw = wt_valid && wt_ready;
            td = data_valid && data_ready;
            step();
            if (tw) iw++;
            if (td) id++;
            ph = ~ph;
        end
        check("fill_w_count", 32'(iw), 32'(DEPTH));
        check("fill_d_count", 32'(id), 32'(nacc));
        check("d_rdy_drop",   32'(data_ready), 32'h0);
        wt_valid   = 1'b0;
        data_valid = 1'b0;

        for (int k = 0; k < int'(DEPTH); k++) begin
            check("sendw_control", 32'(control), 32'h1);
            check("sendw_wt_arr",  wt_arr,       wts[k]);
            check("sendw_data",    data_arr,     32'h0);
            step();
        end

        for (int t = 0; t < ncyc; t++) begin
            check("sendd_control", 32'(control), 32'h0);
            check("sendd_wt_arr",  wt_arr,       32'h0);
            check("sendd_data",    data_arr,     exp_d[t]);
            check("sendd_done",    32'(done),    32'h0);
            if (mode == 2 && t == 2) begin
                rst_n = 1'b0;
                step();
                check_idle_outputs("midrst");
                rst_n = 1'b1;
                step();
                check("midrst_busy_after", 32'(busy), 32'h0);
                return;
            end
            if (mode == 1 && t == 2) begin
                start  = 1'b1;
                n_rows = NW'(4);
            end
            step();
            start  = 1'b0;
            n_rows = '0;
        end

        check("done_pulse", 32'(done),     32'h1);
        check("done_data",  32'(data_arr), 32'h0);
        check("done_busy",  32'(busy),     32'h1);
        step();
        check("post_done",  32'(done),     32'h0);
        check("post_busy",  32'(busy),     32'h0);
        check("post_wtrdy", 32'(wt_ready), 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        n_rows     = '0;
        wt_valid   = 1'b0;
        wt_in      = '0;
        data_valid = 1'b0;
        data_in    = '0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            start      = 1'($urandom);
            n_rows     = NW'($urandom_range(0, 8));
            wt_valid   = 1'($urandom);
            wt_in      = $urandom;
            data_valid = 1'($urandom);
            data_in    = $urandom;
            step();
        end
        check_idle_outputs("reset");
        start      = 1'b0;
        n_rows     = '0;
        wt_valid   = 1'b0;
        data_valid = 1'b0;
        rst_n      = 1'b1;
        step();

        load_canonical();
        run_tile(4, 4, 1'b0, 0, 7);

        run_tile(4, 4, 1'b1, 0, 7);

        rows[0]  = 32'h04030201;
        exp_d[0] = 32'h00000001; exp_d[1] = 32'h00000200;
        exp_d[2] = 32'h00030000; exp_d[3] = 32'h04000000;
        run_tile(1, 1, 1'b0, 0, 4);

        // n_rows = 0 must leave the block idle
        start  = 1'b1;
        n_rows = '0;
        step();
        start  = 1'b0;
        check("nrows0_busy",  32'(busy),     32'h0);
        check("nrows0_wtrdy", 32'(wt_ready), 32'h0);
        step();
        check("nrows0_busy2", 32'(busy),     32'h0);

        // Oversized request clamps to MAX_ROWS
        for (int r = 0; r < 12; r++) rows[r] = 32'h11223344 + 32'(r) * 32'h01030507;
        for (int t = 0; t < 11; t++) exp_d[t] = model_skew(t, 8);
        run_tile(int'(MAX_ROWS) + 3, int'(MAX_ROWS), 1'b0, 0, 11);

        load_canonical();
        run_tile(4, 4, 1'b0, 1, 7);
        step();
        check("start_ignored_busy", 32'(busy), 32'h0);

        run_tile(4, 4, 1'b0, 2, 7);
        run_tile(4, 4, 1'b0, 0, 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
